// File: rtl/ocra1_sched_pkg.sv
// Shared types for the OCRA1 scheduler: channel ids, serialiser word layout, FSM states.
// Pure declarations and helpers; no timing or backpressure of its own.
package ocra1_pkg;

    localparam int NCH       = 4;
    localparam int PAYLOAD_W = 24;
    localparam int CH_LSB    = 25;
    localparam int BCAST_BIT = 24;
    localparam int HOLDOFF   = 3;
    localparam int CNT_W     = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    typedef enum logic [1:0] {
        CH_X  = 2'd0,
        CH_Y  = 2'd1,
        CH_Z  = 2'd2,
        CH_Z2 = 2'd3
    } ch_e;

    typedef enum logic [1:0] {
        ST_STAGE = 2'd0,
        ST_BCAST = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    typedef logic [PAYLOAD_W-1:0] payload_t;

    // Bit layout matches CH_LSB / BCAST_BIT above.
    typedef struct packed {
        logic [4:0] rsvd;
        logic [1:0] ch;
        logic       bcast;
        payload_t   payload;
    } word_t;

    function automatic word_t make_word(input logic [1:0] ch, input logic bcast, input payload_t pl);
        word_t w;
        w         = '0;
        w.ch      = ch;
        w.bcast   = bcast;
        w.payload = pl;
        return w;
    endfunction

endpackage

// File: rtl/ocra1_sched_if.sv
// Per-channel request bundle from the gradient readout into the scheduler.
// Valid/ready per channel; ready is high while that channel's holding register is empty.
interface ocra1_sched_if;
    import ocra1_pkg::*;

    logic [NCH-1:0]           req_valid;
    logic [NCH*PAYLOAD_W-1:0] req_data;
    logic [NCH-1:0]           req_ready;

    modport master (
        output req_valid,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_data,
        output req_ready
    );

endinterface

// File: rtl/ocra1_sched_rr_arb4.sv
// 4-way round-robin arbiter, combinational one-hot grant, pointer moves past the winner.
// Zero-latency grant; every grant is assumed taken by the caller.
module rr_arb4 (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx
);

    logic [1:0] ptr;
    logic [1:0] idx;
    logic       found;

    always_comb begin
        gnt_idx = ptr;
        found   = 1'b0;
        idx     = ptr;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                found   = 1'b1;
                gnt_idx = idx;
            end
        end
        gnt = found ? (4'b0001 << gnt_idx) : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 2'd0;
        end else if (found) begin
            ptr <= gnt_idx + 2'd1;
        end
    end

endmodule

// File: rtl/ocra1_sched.sv
// Stages per-channel DAC words into the OCRA1 shadow registers, then issues the launch broadcast.
// Words appear 2 cycles after acceptance; a channel stays not-ready while its holding register is full.
module ocra1_sched
    import ocra1_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    ocra1_sched_if.slave       req,
    input  logic               commit_i,
    input  logic [NCH-1:0]     auto_mask_i,
    input  logic               busy_i,
    input  logic               data_lost_i,
    output logic [31:0]        data_o,
    output logic               valid_o,
    output logic [NCH-1:0]     staged_o,
    output logic               commit_pending_o,
    output logic               err_o
);

    payload_t          hold [NCH];
    payload_t          last [NCH];
    logic [NCH-1:0]    full;
    logic [NCH-1:0]    staged;
    logic              pend;
    logic              err;
    state_e            state;
    logic [CNT_W-1:0]  cnt;

    logic [NCH-1:0]    accept;
    logic [NCH-1:0]    elig;
    logic [NCH-1:0]    gnt;
    logic [1:0]        gnt_idx;
    logic              gnt_any;
    logic              auto_hit;
    logic              bcast_go;

    assign req.req_ready = ~full;
    assign accept        = req.req_valid & ~full;

    // Staging only happens in STAGE, and a staged channel waits for the next broadcast.
    assign elig     = (state == ST_STAGE) ? (full & ~staged) : '0;
    assign gnt_any  = |gnt;
    assign auto_hit = (auto_mask_i != '0) && ((staged & auto_mask_i) == auto_mask_i);
    assign bcast_go = (state == ST_BCAST) && !busy_i;

    rr_arb4 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (elig),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < NCH; n++) begin
                hold[n] <= '0;
                last[n] <= '0;
            end
            full    <= '0;
            staged  <= '0;
            pend    <= 1'b0;
            err     <= 1'b0;
            state   <= ST_STAGE;
            cnt     <= '0;
            data_o  <= '0;
            valid_o <= 1'b0;
        end else begin
            valid_o <= 1'b0;

            for (int n = 0; n < NCH; n++) begin
                if (accept[n]) begin
                    hold[n] <= req.req_data[n*PAYLOAD_W +: PAYLOAD_W];
                end
            end
            // accept and gnt never hit the same channel: ready needs !full, grant needs full.
            full <= (full | accept) & ~gnt;

            if (gnt_any) begin
                data_o        <= make_word(gnt_idx, 1'b0, hold[gnt_idx]);
                valid_o       <= 1'b1;
                last[gnt_idx] <= hold[gnt_idx];
                staged        <= staged | gnt;
            end

            if ((commit_i && pend) || data_lost_i) begin
                err <= 1'b1;
            end

            if (bcast_go) begin
                pend <= 1'b0;
            end else if (commit_i || ((state == ST_STAGE) && auto_hit)) begin
                pend <= 1'b1;
            end

            case (state)
                ST_STAGE: begin
                    if (pend && !gnt_any) begin
                        state <= ST_BCAST;
                    end
                end
                ST_BCAST: begin
                    if (!busy_i) begin
                        // Rewriting x with its own last value is what launches all four channels.
                        data_o  <= make_word(CH_X, 1'b1, last[0]);
                        valid_o <= 1'b1;
                        staged  <= '0;
                        cnt     <= CNT_W'(HOLDOFF - 1);
                        state   <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (cnt == '0) begin
                        state <= ST_STAGE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= ST_STAGE;
            endcase
        end
    end

    assign staged_o         = staged;
    assign commit_pending_o = pend;
    assign err_o            = err;

endmodule

// File: tb/tb_ocra1_sched.sv
// Directed bench for ocra1_sched: hand-computed words and flags checked cycle by cycle.
module tb_ocra1_sched;
    import ocra1_pkg::*;

    logic        clk;
    logic        rst;
    logic        commit_i;
    logic [3:0]  auto_mask_i;
    logic        busy_i;
    logic        data_lost_i;
    logic [31:0] data_o;
    logic        valid_o;
    logic [3:0]  staged_o;
    logic        commit_pending_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    ocra1_sched_if rif ();

    ocra1_sched dut (
        .clk              (clk),
        .rst              (rst),
        .req              (rif),
        .commit_i         (commit_i),
        .auto_mask_i      (auto_mask_i),
        .busy_i           (busy_i),
        .data_lost_i      (data_lost_i),
        .data_o           (data_o),
        .valid_o          (valid_o),
        .staged_o         (staged_o),
        .commit_pending_o (commit_pending_o),
        .err_o            (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"},   32'(rif.req_ready),   32'hF);
        chk({tag, "_valid"},   32'(valid_o),         32'h0);
        chk({tag, "_data"},    data_o,               32'h0);
        chk({tag, "_staged"},  32'(staged_o),        32'h0);
        chk({tag, "_pending"}, 32'(commit_pending_o), 32'h0);
        chk({tag, "_err"},     32'(err_o),           32'h0);
    endtask

    initial begin
        rst           = 1'b1;
        commit_i      = 1'b0;
        auto_mask_i   = 4'h0;
        busy_i        = 1'b0;
        data_lost_i   = 1'b0;
        rif.req_valid = 4'h0;
        rif.req_data  = '0;
        tick();
        tick();
        chk_reset("rst0");
        rst = 1'b0;

        // x and y together: x first, y next cycle
        rif.req_valid = 4'b0011;
        rif.req_data  = {24'h0, 24'h0, 24'hABCDEF, 24'h123456};
        tick();
        rif.req_valid = 4'b0000;
        chk("xy_ready_drop", 32'(rif.req_ready), 32'hC);
        chk("xy_no_early_word", 32'(valid_o), 32'h0);
        tick();
        chk("x_valid", 32'(valid_o), 32'h1);
        chk("x_word", data_o, 32'h00123456);
        tick();
        chk("y_valid", 32'(valid_o), 32'h1);
        chk("y_word", data_o, 32'h02ABCDEF);
        chk("xy_staged", 32'(staged_o), 32'h3);
        tick();
        chk("xy_idle", 32'(valid_o), 32'h0);
        chk("xy_ready_back", 32'(rif.req_ready), 32'hF);

        // manual commit
        commit_i = 1'b1;
        tick();
        commit_i = 1'b0;
        chk("c1_pending", 32'(commit_pending_o), 32'h1);
        tick();
        chk("c1_enter_bcast", 32'(valid_o), 32'h0);
        tick();
        chk("c1_bcast_valid", 32'(valid_o), 32'h1);
        chk("c1_bcast_word", data_o, 32'h01123456);
        chk("c1_staged_clr", 32'(staged_o), 32'h0);
        chk("c1_pending_clr", 32'(commit_pending_o), 32'h0);

        // commit during HOLD is queued, not an error; it then broadcasts with nothing staged
        commit_i = 1'b1;
        tick();
        commit_i = 1'b0;
        chk("hold_commit_pending", 32'(commit_pending_o), 32'h1);
        chk("hold_commit_no_err", 32'(err_o), 32'h0);
        chk("hold_quiet0", 32'(valid_o), 32'h0);
        tick();
        chk("hold_quiet1", 32'(valid_o), 32'h0);
        tick();
        chk("hold_quiet2", 32'(valid_o), 32'h0);
        tick();
        chk("c2_enter_bcast", 32'(valid_o), 32'h0);
        tick();
        chk("c2_bcast_valid", 32'(valid_o), 32'h1);
        chk("c2_bcast_word", data_o, 32'h01123456);
        tick();
        tick();
        tick();

        // all four with auto-commit; a second x request waits behind the staged x
        auto_mask_i   = 4'hF;
        rif.req_valid = 4'hF;
        rif.req_data  = {24'h444444, 24'h333333, 24'h222222, 24'h111111};
        tick();
        rif.req_valid = 4'b0001;
        rif.req_data  = {24'h444444, 24'h333333, 24'h222222, 24'h555555};
        chk("all_ready_low", 32'(rif.req_ready), 32'h0);
        tick();
        chk("rr_z_word", data_o, 32'h04333333);
        tick();
        chk("rr_z2_word", data_o, 32'h06444444);
        tick();
        chk("rr_x_word", data_o, 32'h00111111);
        tick();
        chk("rr_y_valid", 32'(valid_o), 32'h1);
        chk("rr_y_word", data_o, 32'h02222222);
        chk("x2_held_ready", 32'(rif.req_ready), 32'hE);
        chk("all_staged", 32'(staged_o), 32'hF);
        rif.req_valid = 4'b0000;
        tick();
        chk("auto_no_resend", 32'(valid_o), 32'h0);
        chk("auto_pending", 32'(commit_pending_o), 32'h1);
        tick();
        chk("auto_enter_bcast", 32'(valid_o), 32'h0);
        tick();
        chk("auto_bcast_valid", 32'(valid_o), 32'h1);
        chk("auto_bcast_word", data_o, 32'h01111111);
        chk("auto_staged_clr", 32'(staged_o), 32'h0);
        chk("auto_pending_clr", 32'(commit_pending_o), 32'h0);
        for (int i = 0; i < HOLDOFF; i++) begin
            tick();
            chk($sformatf("holdoff_%0d", i), 32'(valid_o), 32'h0);
        end
        tick();
        chk("x2_valid", 32'(valid_o), 32'h1);
        chk("x2_word", data_o, 32'h00555555);
        chk("x2_no_err", 32'(err_o), 32'h0);

        // busy serialiser holds the broadcast; a second commit while pending is an overrun
        auto_mask_i = 4'h0;
        busy_i      = 1'b1;
        commit_i    = 1'b1;
        tick();
        commit_i = 1'b0;
        chk("busy_pending", 32'(commit_pending_o), 32'h1);
        tick();
        for (int i = 0; i < 17; i++) begin
            if (i == 5) commit_i = 1'b1;
            tick();
            commit_i = 1'b0;
            chk($sformatf("busy_wait_%0d", i), 32'(valid_o), 32'h0);
        end
        chk("overrun_err", 32'(err_o), 32'h1);
        chk("busy_staged_kept", 32'(staged_o), 32'h1);
        busy_i = 1'b0;
        tick();
        chk("busy_bcast_valid", 32'(valid_o), 32'h1);
        chk("busy_bcast_word", data_o, 32'h01555555);

        // reset in the middle of HOLD
        tick();
        rst = 1'b1;
        tick();
        chk_reset("rst_hold");
        rst           = 1'b0;
        rif.req_valid = 4'b0100;
        rif.req_data  = {24'h0, 24'h0ABCDE, 24'h0, 24'h0};
        commit_i      = 1'b1;
        tick();
        rif.req_valid = 4'b0000;
        commit_i      = 1'b0;
        chk("post_rst_ready", 32'(rif.req_ready), 32'hB);
        tick();
        chk("post_rst_z_valid", 32'(valid_o), 32'h1);
        chk("post_rst_z_word", data_o, 32'h040ABCDE);
        tick();
        chk("grant_before_bcast", 32'(valid_o), 32'h0);
        tick();
        chk("zero_bcast_valid", 32'(valid_o), 32'h1);
        chk("zero_bcast_word", data_o, 32'h01000000);
        chk("post_rst_err_clear", 32'(err_o), 32'h0);

        data_lost_i = 1'b1;
        tick();
        data_lost_i = 1'b0;
        chk("data_lost_err", 32'(err_o), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ocra1_sched.md
# ocra1_sched

Scheduler and arbiter in front of the OCRA1 SPI serialiser. It accepts 24-bit DAC words from four independent per-channel requesters (x, y, z, z2) and stages them into the serialiser's shadow registers one word per cycle. It then issues the broadcast word that launches a simultaneous four-channel SPI transfer. It sits between the gradient BRAM readout and the OCRA1 interface, and prevents the serialiser's data-lost condition by construction.

## Interface
- HOLDOFF, 3, cycles after a broadcast word during which no word is sent (covers the serialiser's 2-stage input pipeline plus busy latency)
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_valid_i  in  4  per-channel request valid; bit 0 = x, 1 = y, 2 = z, 3 = z2
- req_data_i  in  96  per-channel payloads; channel n in bits [24n+23:24n]
- req_ready_o  out  4  per-channel ready; high when that channel's holding register is empty
- commit_i  in  1  one-cycle strobe requesting a broadcast
- auto_mask_i  in  4  auto-commit when all masked channels are staged; 0 disables auto-commit
- busy_i  in  1  serialiser busy
- data_lost_i  in  1  serialiser data-lost flag
- data_o  out  32  serialiser word: [26:25] channel, [24] broadcast, [23:0] payload, [31:27] = 0
- valid_o  out  1  one-cycle word strobe
- staged_o  out  4  channels written to the shadow since the last broadcast
- commit_pending_o  out  1  broadcast requested, not yet issued
- err_o  out  1  sticky error: commit overrun or data_lost_i seen; cleared only by rst

## Operation
- Per channel there is a holding register `hold[n]` with a `full[n]` flag, and a copy `last[n]` of the last value sent. Accept a request when `req_valid_i[n] && req_ready_o[n]`, then set `full[n]`.
- Staging:
  - Eligible channels satisfy `full[n] && !staged[n]`.
  - A round-robin arbiter picks one eligible channel per cycle. The pointer starts at x and advances past the granted channel.
  - On a grant, emit a word with broadcast = 0 and payload = `hold[n]`. Then clear `full[n]`, set `staged[n]`, and set `last[n] = hold[n]`.
  - A channel already staged is never re-sent before the next broadcast. Its new request waits in `hold` with ready low.
- Commit request:
  - `commit_i` sets `commit_pending`.
  - `commit_pending` is also set internally when `auto_mask_i != 0` and `(staged & auto_mask_i) == auto_mask_i`.
  - If `commit_i` arrives while `commit_pending` is already set, it is dropped and `err_o` is set.
- FSM states: STAGE, BCAST, HOLD.
  - STAGE: staging proceeds. Go to BCAST when `commit_pending` is set and no staging grant is issued this cycle.
  - BCAST: no staging. When `!busy_i`:
    - Emit a word with channel 0, broadcast = 1, payload = `last[0]`. This rewrites x's shadow with its own value.
    - Clear `staged` and `commit_pending`, load the counter with HOLDOFF-1, and go to HOLD.
  - HOLD: no words are emitted. Count down; go to STAGE at 0.
- `data_lost_i` high in any cycle sets `err_o`.
- Reset:
  - `hold`, `last`, `full`, `staged` and `commit_pending` are cleared; the FSM returns to STAGE; the arbiter pointer goes to x.
  - A reset mid-HOLD abandons the countdown. Serialiser state is not affected.

## Timing
- Reset values: `req_ready_o` = 4'hF, `valid_o` = 0, `data_o` = 0, `staged_o` = 0, `commit_pending_o` = 0, `err_o` = 0.
- All outputs are registered.
  - An accepted request reaches `valid_o` no earlier than the 2nd cycle after acceptance.
  - `req_ready_o[n]` drops the cycle after acceptance.
- `valid_o` is high for at most 1 cycle per word. Words may be issued back-to-back, and only in STAGE or BCAST.
- Broadcast latency: the broadcast word issues on the first cycle in BCAST with `busy_i` low. No word is emitted for the following HOLDOFF cycles.
- Simultaneous events:
  - Commit detection and a staging grant in the same cycle: the grant wins and the broadcast follows.
  - `commit_i` during HOLD is held pending and is not an error.
  - Request accept and staging of the same channel in the same cycle is impossible, because ready requires `!full`.

## Structure
- Shared package `ocra1_pkg` holds:
  - the channel enum (X = 0, Y = 1, Z = 2, Z2 = 3);
  - word field constants (CH_LSB = 25, BCAST_BIT = 24, PAYLOAD_W = 24);
  - the FSM state typedef.
- One sub-module is natural: `rr_arb4`, a 4-way round-robin arbiter with a one-hot grant and pointer update.

## Test plan
- Reset, then request x = 24'h123456 and y = 24'hABCDEF in the same cycle → two words, 32'h00123456 then 32'h02ABCDEF, on consecutive cycles; `staged_o` = 4'b0011.
- Set `auto_mask_i` = 4'hF and request all four channels with `busy_i` = 0 → four staging words, then broadcast 32'h01000000|`last[0]`; no `valid_o` for the next 3 cycles; `staged_o` = 0.
- Stage x and send a second x request before the commit → the second value is held with `req_ready_o[0]` = 0 and is sent only after the broadcast plus HOLDOFF; `err_o` stays 0.
- Pulse `commit_i` with `busy_i` high for 20 cycles → broadcast on the cycle after `busy_i` falls; a second `commit_i` during the wait sets `err_o`.
- With nothing staged, pulse `commit_i` → one broadcast word with payload `last[0]` (0 after reset).
- Assert `rst` during HOLD → next cycle all outputs are at reset values and staging resumes immediately.
